// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes for ports 0/1 plus the RAM16K side.
// slave = arbiter view, master = requester/RAM view.
interface ram_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 16
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_in;
    logic          mem_load;
    logic [DW-1:0] mem_out;
    logic          busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_out,
        output ack0, rdata0, ack1, rdata1,
        output mem_address, mem_in, mem_load, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_out,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_address, mem_in, mem_load, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM16K between two requesters.
// Each access runs IDLE/ACK -> ACC -> ACK; ack is a one-cycle pulse in ACK.
// Ties are round-robin by default; define ARB_FIXED_PRIORITY_EN to make
// port 0 always win a tie.
module ram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic         clock,
    input  logic         reset,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_in_q, mem_in_d;

    logic elig0, elig1, tie_win, win, we_sel;

    // Arbitration, access sequencing and read-data capture
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        mem_address_d = mem_address_q;
        mem_in_d      = mem_in_q;

        // The port being acked must drop req this cycle, so it is masked.
        elig0 = bus.req0 & ~((state_q == ACK) & ~owner_q);
        elig1 = bus.req1 & ~((state_q == ACK) &  owner_q);
`ifdef ARB_FIXED_PRIORITY_EN
        tie_win = 1'b0;
`else
        tie_win = ~last_q;
`endif
        win = (elig0 & elig1) ? tie_win : elig1;

        case (state_q)
            IDLE, ACK: begin
                if (elig0 | elig1) begin
                    state_d = ACC;
                    owner_d = win;
                    // Request fields are stable while req is high, so
                    // capturing at grant equals driving them during ACC and
                    // leaves the bus holding the last values afterwards.
                    mem_address_d = win ? bus.addr1  : bus.addr0;
                    mem_in_d      = win ? bus.wdata1 : bus.wdata0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (!owner_q && !bus.we0) rdata0_d = bus.mem_out;
                if ( owner_q && !bus.we1) rdata1_d = bus.mem_out;
                last_d  = owner_q;
                state_d = ACK;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            mem_address_q <= '0;
            mem_in_q      <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            mem_address_q <= mem_address_d;
            mem_in_q      <= mem_in_d;
        end
    end

    // Reset gates the write so a reset landing in ACC never commits.
    assign we_sel          = owner_q ? bus.we1 : bus.we0;
    assign bus.mem_load    = (state_q == ACC) & we_sel & ~reset;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_in      = mem_in_q;
    assign bus.busy        = (state_q == ACC);
    // Acks decode registered state, so a reset in ACK still shows the pulse.
    assign bus.ack0        = (state_q == ACK) & ~owner_q;
    assign bus.ack1        = (state_q == ACK) &  owner_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with an ack scoreboard; a behavioural
// RAM16K sits on the memory side.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(14), .DW(16)) bus ();
    ram_arbiter #(.AW(14), .DW(16)) dut (.clock(clk), .reset(rst), .bus(bus.slave));

    logic [15:0] ram [0:16383];
    assign bus.mem_out = ram[bus.mem_address];
    always @(posedge clk) if (bus.mem_load) ram[bus.mem_address] <= bus.mem_in;

    typedef struct { bit port; logic [15:0] rd0; logic [15:0] rd1; } exp_t;
    exp_t sbq[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit p, input logic [15:0] r0, input logic [15:0] r1);
        exp_t e;
        e.port = p; e.rd0 = r0; e.rd1 = r1;
        sbq.push_back(e);
    endtask

    // One access on port p; checks req-to-ack latency in cycles.
    task automatic req_port(input bit p, input bit we, input logic [13:0] a,
                            input logic [15:0] d, input int exp_lat);
        int n;
        bit got;
        @(negedge clk);
        if (p) begin bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1; end
        else   begin bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1; end
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            got = p ? bus.ack1 : bus.ack0;
        end
        if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        if (!got) chk(p ? "timeout_p1" : "timeout_p0", 1, 0);
        else      chk(p ? "latency_p1" : "latency_p0", n, exp_lat);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every ack pops one expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                chk("ack_onehot", {31'd0, bus.ack0 & bus.ack1}, 0);
                if (sbq.size() == 0) chk("unexpected_ack", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("ack_port", {31'd0, bus.ack1}, {31'd0, e.port});
                    chk("rdata0", {16'd0, bus.rdata0}, {16'd0, e.rd0});
                    chk("rdata1", {16'd0, bus.rdata1}, {16'd0, e.rd1});
                end
            end
        end
    end

    initial begin
        int acks, cyc;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 16384; i++) ram[i] = 16'h0000;
        ram[14'h0010] = 16'h1111;
        ram[14'h0011] = 16'h2222;
        ram[14'h3FFF] = 16'h5A5A;

        // 1: reset state
        repeat (2) @(negedge clk);
        chk("rst_ack0",   {31'd0, bus.ack0}, 0);
        chk("rst_ack1",   {31'd0, bus.ack1}, 0);
        chk("rst_rdata0", {16'd0, bus.rdata0}, 0);
        chk("rst_rdata1", {16'd0, bus.rdata1}, 0);
        chk("rst_load",   {31'd0, bus.mem_load}, 0);
        chk("rst_busy",   {31'd0, bus.busy}, 0);
        rst = 1'b0;

        // 2: port 0 write then read back
        push(0, 16'h0000, 16'h0000);
        req_port(0, 1, 14'h0005, 16'h1234, 2);
        push(0, 16'h1234, 16'h0000);
        req_port(0, 0, 14'h0005, 16'h0000, 2);
        chk("ram_0005", {16'd0, ram[14'h0005]}, 32'h1234);

        // 3: simultaneous reads after reset, port 0 first, back-to-back
        do_reset();
        push(0, 16'h1111, 16'h0000);
        push(1, 16'h1111, 16'h2222);
        fork
            req_port(0, 0, 14'h0010, 16'h0000, 2);
            req_port(1, 0, 14'h0011, 16'h0000, 4);
        join

        // 4: both ports hold req, 8 accesses alternate 0,1,0,1...
        do_reset();
        push(0, 16'h1111, 16'h0000);
        for (int i = 0; i < 7; i++) push(((i % 2) == 0), 16'h1111, 16'h2222);
        @(negedge clk);
        bus.we0 = 0; bus.addr0 = 14'h0010; bus.req0 = 1;
        bus.we1 = 0; bus.addr1 = 14'h0011; bus.req1 = 1;
        acks = 0; cyc = 0;
        while (acks < 8 && cyc < 100) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus.ack0 || bus.ack1) acks++;
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("t4_acks", acks, 8);
        chk("t4_cycles", cyc, 16);

        // 5: port 1 write aborted by reset during ACC
        @(negedge clk);
        bus.we1 = 1; bus.addr1 = 14'h3FFF; bus.wdata1 = 16'hBEEF; bus.req1 = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_busy", {31'd0, bus.busy}, 1);
        rst = 1'b1;
        bus.req1 = 0;
        #1;
        chk("t5_load_gated", {31'd0, bus.mem_load}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t5_ram_3fff", {16'd0, ram[14'h3FFF]}, 32'h5A5A);
        push(1, 16'h0000, 16'h5A5A);
        req_port(1, 0, 14'h3FFF, 16'h0000, 2);

        // 6: same address, write from port 0 then read from port 1
        push(0, 16'h0000, 16'h5A5A);
        push(1, 16'h0000, 16'hAAAA);
        fork
            req_port(0, 1, 14'h0100, 16'hAAAA, 2);
            req_port(1, 0, 14'h0100, 16'h0000, 4);
        join

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
